// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: key/word types, round constants, forward S-box
// and the GF(2^8) helpers used by the equivalent-inverse-cipher key path.
package aes_pkg;

    typedef logic [127:0] key_t;
    typedef logic [31:0]  word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int NUM_ROUNDS = 10;

    // Indexed by the round the key belongs to: stepping back from round r uses RCON[r].
    localparam logic [7:0] RCON [0:NUM_ROUNDS] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ a;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Byte 0 of the column sits in [31:24].
    function automatic word_t inv_mix_col(input word_t w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
    endfunction

endpackage

// File: rtl/sub_word.sv
// Four parallel forward S-boxes on a 32-bit word, purely combinational.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        assign o_word[8*gi +: 8] = SBOX[i_word[8*gi +: 8]];
    end

endmodule

// File: rtl/inv_key_sched.sv
// Iterative AES-128 inverse key schedule: streams round keys 10..0 over valid/ready.
// Define INV_KEY_SCHED_EQINV_EN to emit InvMixColumns-transformed keys for rounds 9..1.
//
// state | meaning
// IDLE  | waiting for i_start; key register holds last value
// RUN   | o_rkey valid; steps back one round per accepted transfer
module inv_key_sched
    import aes_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_key_last,
    input  logic         i_rkey_ready,
    output logic [127:0] o_rkey,
    output logic         o_rkey_valid,
    output logic [3:0]   o_round,
    output logic         o_busy,
    output logic         o_done
);

    state_t      state_q, state_d;
    key_t        key_q, key_d;
    logic [3:0]  round_q, round_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        done_q, done_d;

    logic        fire;
    logic        last_round;
    word_t       w0, w1, w2, w3;
    word_t       p0, p1, p2, p3;
    word_t       rot_p3, sub_p3;

    assign fire       = (state_q == ST_RUN) && i_rkey_ready;
    assign last_round = (round_q == 4'd0);

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // Undo the forward expansion: each word is the XOR of its two successors.
    assign p3     = w3 ^ w2;
    assign p2     = w2 ^ w1;
    assign p1     = w1 ^ w0;
    assign rot_p3 = {p3[23:0], p3[31:24]};

    sub_word u_sub_word (
        .i_word (rot_p3),
        .o_word (sub_p3)
    );

    assign p0 = w0 ^ sub_p3 ^ {rcon_q, 24'h0};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start)           state_d = ST_RUN;
            ST_RUN:  if (fire && last_round) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (i_start) begin
                key_d   = i_key_last;
                round_d = 4'(NUM_ROUNDS);
                rcon_d  = RCON[NUM_ROUNDS];
            end
        end else if (fire) begin
            if (last_round) begin
                done_d = 1'b1;
            end else begin
                key_d   = {p0, p1, p2, p3};
                round_d = round_q - 4'd1;
                rcon_d  = RCON[round_q - 4'd1];
            end
        end
    end

    always_comb begin
        o_rkey_valid = (state_q == ST_RUN);
        o_busy       = (state_q == ST_RUN);
        o_round      = round_q;
        o_done       = done_q;
        o_rkey       = key_q;
`ifdef INV_KEY_SCHED_EQINV_EN
        // Middle rounds feed the equivalent inverse cipher; the end rounds stay raw.
        if (round_q != 4'd0 && round_q != 4'(NUM_ROUNDS)) begin
            o_rkey = {inv_mix_col(w0), inv_mix_col(w1), inv_mix_col(w2), inv_mix_col(w3)};
        end
`endif
    end

endmodule

// File: tb/tb_inv_key_sched.sv
// Self-checking bench for inv_key_sched: scoreboard of expected round keys (FIPS-197 A.1),
// popped by a monitor on each accepted transfer.
module tb_inv_key_sched;

    logic         i_clk;
    logic         i_rst;
    logic         i_start;
    logic [127:0] i_key_last;
    logic         i_rkey_ready;
    logic [127:0] o_rkey;
    logic         o_rkey_valid;
    logic [3:0]   o_round;
    logic         o_busy;
    logic         o_done;

    inv_key_sched dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_key_last   (i_key_last),
        .i_rkey_ready (i_rkey_ready),
        .o_rkey       (o_rkey),
        .o_rkey_valid (o_rkey_valid),
        .o_round      (o_round),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] fips [0:10];
    int           n_tests = 0;
    int           n_fail  = 0;
    bit           exp_done = 1'b0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] model_imc(input logic [31:0] w);
        logic [7:0] a [4];
        for (int i = 0; i < 4; i++) a[i] = w[31-8*i -: 8];
        return {gf_mul(a[0], 8'd14) ^ gf_mul(a[1], 8'd11) ^ gf_mul(a[2], 8'd13) ^ gf_mul(a[3], 8'd9),
                gf_mul(a[0], 8'd9)  ^ gf_mul(a[1], 8'd14) ^ gf_mul(a[2], 8'd11) ^ gf_mul(a[3], 8'd13),
                gf_mul(a[0], 8'd13) ^ gf_mul(a[1], 8'd9)  ^ gf_mul(a[2], 8'd14) ^ gf_mul(a[3], 8'd11),
                gf_mul(a[0], 8'd11) ^ gf_mul(a[1], 8'd13) ^ gf_mul(a[2], 8'd9)  ^ gf_mul(a[3], 8'd14)};
    endfunction

    function automatic logic [127:0] expected_key(input int r);
        logic [127:0] k;
        k = fips[r];
`ifdef INV_KEY_SCHED_EQINV_EN
        if (r >= 1 && r <= 9)
            k = {model_imc(k[127:96]), model_imc(k[95:64]), model_imc(k[63:32]), model_imc(k[31:0])};
`endif
        return k;
    endfunction

    task automatic push_run();
        exp_t e;
        for (int r = 10; r >= 0; r--) begin
            e.rnd = 4'(r);
            e.key = expected_key(r);
            sb.push_back(e);
        end
    endtask

    task automatic start_run();
        push_run();
        @(posedge i_clk);
        #1 i_start = 1'b1;
        i_key_last = fips[10];
        @(posedge i_clk);
        #1 i_start = 1'b0;
    endtask

    task automatic drain(input int budget, input bit rand_ready);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge i_clk);
            #1;
            if (rand_ready) i_rkey_ready = 1'($urandom_range(0, 1));
            #1;
            if (sb.size() == 0 && !exp_done) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", 128'd0, 128'd1);
        i_rkey_ready = 1'b1;
    endtask

    // Monitor: outputs sampled on the falling edge, inputs are stable there.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            chk("done", {127'd0, o_done}, {127'd0, exp_done});
            exp_done = 1'b0;
            if (o_rkey_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 128'd1, 128'd0);
                end else begin
                    chk("round", {124'd0, o_round}, {124'd0, sb[0].rnd});
                    chk("rkey", o_rkey, sb[0].key);
                    if (i_rkey_ready) begin
                        if (sb[0].rnd == 4'd0) exp_done = 1'b1;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_key_last   = '0;
        i_rkey_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_valid", {127'd0, o_rkey_valid}, 128'd0);
        chk("rst_round", {124'd0, o_round}, 128'd0);
        chk("rst_rkey", o_rkey, 128'd0);
        chk("rst_busy", {127'd0, o_busy}, 128'd0);
        chk("rst_done", {127'd0, o_done}, 128'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;

        // FIPS run with ready held high, plus first-key latency.
        push_run();
        @(posedge i_clk);
        #1 i_start = 1'b1;
        i_key_last = fips[10];
        chk("idle_valid", {127'd0, o_rkey_valid}, 128'd0);
        @(posedge i_clk);
        #1;
        chk("start_lat_valid", {127'd0, o_rkey_valid}, 128'd1);
        chk("start_lat_round", {124'd0, o_round}, 128'd10);
        chk("start_busy", {127'd0, o_busy}, 128'd1);
        i_start = 1'b0;
        drain(40, 1'b0);
        chk("idle_busy", {127'd0, o_busy}, 128'd0);

        // Pseudo-random backpressure.
        start_run();
        drain(400, 1'b1);

        // i_start with a different key while running must be ignored.
        start_run();
        @(posedge i_clk);
        #1 i_start = 1'b1;
        i_key_last = 128'h00112233445566778899aabbccddeeff;
        repeat (3) @(posedge i_clk);
        #1 i_start = 1'b0;
        drain(40, 1'b0);

        // Reset after round 6 is accepted.
        start_run();
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge i_clk);
            if (o_rkey_valid && o_round == 4'd6) found = 1'b1;
        end
        if (!found) chk("wait_round6_timeout", 128'd0, 128'd1);
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        i_rkey_ready = 1'b0;
        sb.delete();
        exp_done = 1'b0;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        chk("mid_rst_valid", {127'd0, o_rkey_valid}, 128'd0);
        chk("mid_rst_round", {124'd0, o_round}, 128'd0);
        chk("mid_rst_rkey", o_rkey, 128'd0);
        chk("mid_rst_busy", {127'd0, o_busy}, 128'd0);
        chk("mid_rst_done", {127'd0, o_done}, 128'd0);
        i_rkey_ready = 1'b1;
        start_run();
        drain(40, 1'b0);

        // Back-to-back: start held high across o_done.
        push_run();
        push_run();
        @(posedge i_clk);
        #1 i_start = 1'b1;
        i_key_last = fips[10];
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge i_clk);
            if (o_rkey_valid && o_round == 4'd0) found = 1'b1;
        end
        if (!found) chk("wait_round0_timeout", 128'd0, 128'd1);
        @(negedge i_clk);
        chk("b2b_gap_valid", {127'd0, o_rkey_valid}, 128'd0);
        @(negedge i_clk);
        chk("b2b_restart_valid", {127'd0, o_rkey_valid}, 128'd1);
        chk("b2b_restart_round", {124'd0, o_round}, 128'd10);
        i_start = 1'b0;
        drain(40, 1'b0);

        repeat (2) @(posedge i_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
